// File: rtl/wb_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module   : wb_cmd_master
//  Purpose  : Wishbone B4 classic initiator. Each command accepted on the
//             cmd_* valid/ready port becomes one single-beat read or write
//             cycle on the wbm_* bus. The result comes back on the rsp_*
//             valid/ready port. Only one transaction is outstanding at a time.
//
//  Optional : `define WB_CMD_MASTER_TIMEOUT_EN adds a TW-bit ack timeout
//             counter. When the counter expires, the cycle is aborted and
//             rsp_err_o is set. Without the macro, the bus waits for ack
//             forever and rsp_err_o is tied low.
//
//  Ports    : wb_clk_i, wb_rst_i    clock, async active-high reset
//             cmd_valid_i/ready_o   command handshake
//             cmd_we/adr/dat/sel_i  command payload
//             rsp_valid_o/ready_i   response handshake
//             rsp_dat_o, rsp_err_o  read data (0 for writes/errors), timeout
//             wbm_cyc/stb/we/sel/adr/dat_o, wbm_ack_i, wbm_dat_i  Wishbone
//
//  Revision : 1.0  initial release
// ============================================================================
module wb_cmd_master #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TW      = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_accept;
    logic        w_bus_done;
    logic        w_expire;

    logic        r_we;
    logic [3:0]  r_sel;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic [31:0] r_rsp_dat;

    // ------------------------------------------------------------------
    // Ack timeout
    // ------------------------------------------------------------------
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    localparam logic [TW-1:0] c_last_count = TW'(TIMEOUT - 1);

    logic [TW-1:0] r_cnt;
    logic          r_rsp_err;

    // The counter sits at zero outside BUS, so it is cleared on BUS entry.
    // Expiry is flagged while the count is TIMEOUT-1. That way, the abort
    // edge is the one on which the count would reach TIMEOUT.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_cnt <= '0;
        end else if (r_state != S_BUS) begin
            r_cnt <= '0;
        end else if (!wbm_ack_i) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_expire = (r_state == S_BUS) && (r_cnt == c_last_count);

    // Ack takes priority over expiry, so err is set only when ack is absent.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_rsp_err <= 1'b0;
        end else if (w_bus_done) begin
            r_rsp_err <= !wbm_ack_i;
        end
    end

    assign rsp_err_o = r_rsp_err;
`else
    logic w_unused_cfg;

    assign w_expire     = 1'b0;
    assign rsp_err_o    = 1'b0;
    assign w_unused_cfg = ^{TIMEOUT, TW};
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_bus_done   = 1'b0;
        cmd_ready_o  = 1'b0;
        rsp_valid_o  = 1'b0;
        wbm_cyc_o    = 1'b0;
        wbm_stb_o    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Reset holds the state in IDLE. Ready is masked so that it
                // reads 0 for as long as reset stays asserted.
                cmd_ready_o = !wb_rst_i;
                if (cmd_valid_i && !wb_rst_i) begin
                    w_accept     = 1'b1;
                    w_state_next = S_BUS;
                end
            end
            S_BUS: begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
                if (wbm_ack_i || w_expire) begin
                    w_bus_done   = 1'b1;
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bus payload and response data registers
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_we      <= 1'b0;
            r_sel     <= 4'd0;
            r_adr     <= 32'd0;
            r_dat     <= 32'd0;
            r_rsp_dat <= 32'd0;
        end else begin
            if (w_accept) begin
                r_we  <= cmd_we_i;
                r_sel <= cmd_sel_i;
                r_adr <= cmd_adr_i;
                r_dat <= cmd_dat_i;
            end
            // Only an acked read returns bus data. Writes and aborts return 0.
            if (w_bus_done) begin
                r_rsp_dat <= (wbm_ack_i && !r_we) ? wbm_dat_i : 32'd0;
            end
        end
    end

    assign wbm_we_o  = r_we;
    assign wbm_sel_o = r_sel;
    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_dat;
    assign rsp_dat_o = r_rsp_dat;

endmodule
`default_nettype wire

// File: tb/tb_wb_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_cmd_master
//  Purpose  : Self-checking bench for wb_cmd_master. A table of directed
//             transactions is applied, followed by hand-written handshake,
//             reset, and timeout / long-wait sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_cmd_master;

    localparam int unsigned TB_TIMEOUT = 8;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_we_i = 1'b0;
    logic [31:0] cmd_adr_i = 32'd0;
    logic [31:0] cmd_dat_i = 32'd0;
    logic [3:0]  cmd_sel_i = 4'd0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i = 1'b0;
    logic [31:0] wbm_dat_i = 32'd0;

    int n_checks = 0;
    int n_fail   = 0;

    wb_cmd_master #(
        .TIMEOUT (TB_TIMEOUT),
        .TW      (4)
    ) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_we_i    (cmd_we_i),
        .cmd_adr_i   (cmd_adr_i),
        .cmd_dat_i   (cmd_dat_i),
        .cmd_sel_i   (cmd_sel_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_dat_o   (rsp_dat_o),
        .rsp_err_o   (rsp_err_o),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_ack_i   (wbm_ack_i),
        .wbm_dat_i   (wbm_dat_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          waits;    // ack driven in BUS cycle index 'waits'; -1 = never
        logic [31:0] rdata;    // slave data presented with ack
        int          hold;     // cycles rsp_ready_i stays low in RESP
        int          exp_n;    // expected cyc/stb high cycles
        logic [31:0] exp_dat;
        logic        exp_err;
    } vec_t;

    task automatic check(input string tag, input string what,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %h, expected %h", tag, what, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic do_txn(input vec_t v);
        int   n;
        logic bad;
        logic bad_hold;
        cmd_valid_i = 1'b1;
        cmd_we_i    = v.we;
        cmd_adr_i   = v.adr;
        cmd_dat_i   = v.dat;
        cmd_sel_i   = v.sel;
        tick();
        cmd_valid_i = 1'b0;
        cmd_adr_i   = ~v.adr;
        cmd_dat_i   = ~v.dat;
        cmd_sel_i   = ~v.sel;
        cmd_we_i    = ~v.we;
        n   = 0;
        bad = 1'b0;
        while (wbm_cyc_o && n < 2000) begin
            if (!wbm_stb_o || wbm_we_o !== v.we || wbm_adr_o !== v.adr ||
                wbm_sel_o !== v.sel || wbm_dat_o !== v.dat ||
                rsp_valid_o || cmd_ready_o)
                bad = 1'b1;
            wbm_ack_i = (n == v.waits);
            wbm_dat_i = (n == v.waits) ? v.rdata : 32'hDEAD_BEEF;
            tick();
            n++;
            wbm_ack_i = 1'b0;
            wbm_dat_i = 32'h0BAD_0BAD;
        end
        check(v.name, "bus_signals_bad", 32'(bad), 32'd0);
        check(v.name, "cyc_cycles", n, v.exp_n);
        check(v.name, "rsp_valid", 32'(rsp_valid_o), 32'd1);
        bad_hold = 1'b0;
        for (int i = 0; i < v.hold; i++) begin
            wbm_ack_i = 1'b1;              // stray ack outside BUS
            wbm_dat_i = $urandom;
            tick();
            if (!rsp_valid_o || rsp_dat_o !== v.exp_dat ||
                rsp_err_o !== v.exp_err || cmd_ready_o || wbm_cyc_o)
                bad_hold = 1'b1;
        end
        wbm_ack_i = 1'b0;
        check(v.name, "hold_unstable", 32'(bad_hold), 32'd0);
        check(v.name, "rsp_dat", rsp_dat_o, v.exp_dat);
        check(v.name, "rsp_err", 32'(rsp_err_o), 32'(v.exp_err));
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        check(v.name, "after_take{valid,ready}", {30'd0, rsp_valid_o, cmd_ready_o}, 32'd1);
    endtask

    vec_t vecs[5];
    vec_t v;
    logic bad;
    int   n;

    initial begin
        vecs[0] = '{"wr_ack1",    1'b1, 32'h3000_0004, 32'hA5A5_0001, 4'hF,  0, 32'h1111_2222, 0, 1, 32'h0000_0000, 1'b0};
        vecs[1] = '{"rd_3wait",   1'b0, 32'h3000_0010, 32'h0000_0000, 4'hF,  3, 32'h1234_5678, 5, 4, 32'h1234_5678, 1'b0};
        vecs[2] = '{"rd_1wait",   1'b0, 32'h0000_0000, 32'h0000_0000, 4'h1,  1, 32'hCAFE_BABE, 1, 2, 32'hCAFE_BABE, 1'b0};
        vecs[3] = '{"wr_2wait",   1'b1, 32'hFFFF_FFFC, 32'h0BAD_F00D, 4'hA,  2, 32'h5555_AAAA, 2, 3, 32'h0000_0000, 1'b0};
        vecs[4] = '{"rd_allones", 1'b0, 32'h8000_0000, 32'h1357_9BDF, 4'h3,  0, 32'hFFFF_FFFF, 0, 1, 32'hFFFF_FFFF, 1'b0};

        // Reset state
        #12;
        check("reset", "outputs_during_reset",
              {24'd0, cmd_ready_o, rsp_valid_o, rsp_err_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, 2'b00}, 32'd0);
        check("reset", "adr|dat|sel|rdat", wbm_adr_o | wbm_dat_o | {28'd0, wbm_sel_o} | rsp_dat_o, 32'd0);
        tick();
        wb_rst_i = 1'b0;
        #1;
        check("reset", "cmd_ready_after_release", 32'(cmd_ready_o), 32'd1);

        // Table of directed transactions
        for (int i = 0; i < 5; i++) begin
            do_txn(vecs[i]);
        end

        // Handshake integrity: valid held high, address churning
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b0;
        cmd_sel_i   = 4'hF;
        cmd_adr_i   = 32'h1000_0040;
        wbm_dat_i   = 32'h7777_0000;
        tick();
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cmd_adr_i = $urandom;
            if (!wbm_cyc_o || wbm_adr_o !== 32'h1000_0040) bad = 1'b1;
            wbm_ack_i = (i == 2);
            tick();
            wbm_ack_i = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            cmd_adr_i = $urandom;
            if (cmd_ready_o || !rsp_valid_o || wbm_cyc_o || wbm_adr_o !== 32'h1000_0040) bad = 1'b1;
            tick();
        end
        check("handshake", "no_second_accept_bad", 32'(bad), 32'd0);
        check("handshake", "rsp_dat", rsp_dat_o, 32'h7777_0000);
        cmd_adr_i   = 32'h2222_0008;
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        check("handshake", "E2{cyc,ready}", {30'd0, wbm_cyc_o, cmd_ready_o}, 32'd1);
        tick();
        cmd_valid_i = 1'b0;
        check("handshake", "next_cyc", 32'(wbm_cyc_o), 32'd1);
        check("handshake", "next_adr", wbm_adr_o, 32'h2222_0008);
        wbm_ack_i = 1'b1;
        tick();
        wbm_ack_i   = 1'b0;
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;

        // Reset mid-BUS
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b0;
        cmd_adr_i   = 32'h2000_0000;
        tick();
        cmd_valid_i = 1'b0;
        tick();
        check("rst_mid_bus", "cyc_before", 32'(wbm_cyc_o), 32'd1);
        #3 wb_rst_i = 1'b1;
        #1;
        check("rst_mid_bus", "{cyc,stb,rvalid,ready}",
              {28'd0, wbm_cyc_o, wbm_stb_o, rsp_valid_o, cmd_ready_o}, 32'd0);
        check("rst_mid_bus", "wbm_adr", wbm_adr_o, 32'd0);
        #2 wb_rst_i = 1'b0;
        #1;
        check("rst_mid_bus", "cmd_ready_release", 32'(cmd_ready_o), 32'd1);
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wbm_ack_i = 1'b1;
            tick();
            if (rsp_valid_o || wbm_cyc_o || !cmd_ready_o) bad = 1'b1;
        end
        wbm_ack_i = 1'b0;
        check("rst_mid_bus", "no_response_bad", 32'(bad), 32'd0);

`ifdef WB_CMD_MASTER_TIMEOUT_EN
        v = '{"timeout", 1'b0, 32'h4000_0000, 32'h0, 4'hF, -1, 32'h9999_9999, 2, TB_TIMEOUT, 32'h0, 1'b1};
        do_txn(v);
        v = '{"ack_on_last", 1'b0, 32'h4000_0004, 32'h0, 4'hF, TB_TIMEOUT - 1, 32'h8888_1234, 0, TB_TIMEOUT, 32'h8888_1234, 1'b0};
        do_txn(v);
        v = '{"wr_timeout", 1'b1, 32'h4000_0008, 32'hFEED_0001, 4'h5, -1, 32'h9999_9999, 0, TB_TIMEOUT, 32'h0, 1'b1};
        do_txn(v);
`else
        v = '{"long_wait", 1'b0, 32'h5000_0000, 32'h0, 4'hF, 999, 32'hABCD_EF01, 1, 1000, 32'hABCD_EF01, 1'b0};
        do_txn(v);
`endif

        n = n_fail;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/wb_cmd_master.md
# wb_cmd_master

Wishbone classic initiator for the user area: turns single-beat commands from a local valid/ready port into Wishbone B4 classic read/write cycles toward a downstream slave. It returns read data or an error over a separate valid/ready response port. It is the bus-initiating counterpart to the user project's Wishbone slave port. Typical uses are driving an internal peripheral from logic-analyzer or GPIO-sourced command logic, and self-test of slave blocks.

## Interface
Parameters:
- TIMEOUT, 255, bus cycles to wait for ack before aborting (1..65535)
- TW, 16, width of the timeout counter; must satisfy 2^TW > TIMEOUT

Ports:
- wb_clk_i  in  1  sole clock, rising edge
- wb_rst_i  in  1  reset, asynchronous, active-high
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted when valid & ready at an edge
- cmd_we_i  in  1  1 = write, 0 = read
- cmd_adr_i  in  32  byte address
- cmd_dat_i  in  32  write data
- cmd_sel_i  in  4  byte lane selects
- rsp_valid_o  out  1  response present; held until taken
- rsp_ready_i  in  1  response consumed when valid & ready at an edge
- rsp_dat_o  out  32  read data (0 for writes and for errors)
- rsp_err_o  out  1  1 = timeout abort
- wbm_cyc_o, wbm_stb_o  out  1 each  Wishbone cycle / strobe
- wbm_we_o  out  1  write enable
- wbm_sel_o  out  4  byte selects
- wbm_adr_o  out  32  address
- wbm_dat_o  out  32  write data
- wbm_ack_i  in  1  slave acknowledge
- wbm_dat_i  in  32  slave read data

## Operation
- FSM states: IDLE -> BUS -> RESP -> IDLE.
- IDLE:
  - cmd_ready_o = 1.
  - On accept, latch we/adr/dat/sel into the wbm_* output registers and go to BUS.
- BUS:
  - wbm_cyc_o = wbm_stb_o = 1; all other wbm_* outputs stable.
  - On an edge with wbm_ack_i = 1, drop cyc/stb, capture rsp_dat_o (wbm_dat_i for reads, 0 for writes), set rsp_err_o = 0, go to RESP.
- RESP:
  - rsp_valid_o = 1 and cmd_ready_o = 0.
  - On rsp_ready_i = 1, go to IDLE.
- Only one outstanding transaction. No pipelined mode and no burst/CTI support.
- wbm_ack_i outside BUS is ignored.
- wbm_dat_o / wbm_adr_o / wbm_sel_o / wbm_we_o retain their last values outside BUS; no zeroing required.
- Reset (asserted at any time, including mid-BUS): immediately return to IDLE. All outputs are 0 except cmd_ready_o, which is 1 once reset is released (0 while wb_rst_i is high). The aborted transaction produces no response.

## Timing
- Command accepted at edge E0: cyc/stb high from E0 until the ack edge.
- Ack sampled high at edge E1 (E1 >= E0+1): cyc/stb low and rsp_valid_o high after E1. Minimum command-to-response latency is 2 cycles.
- Response taken at edge E2: cmd_ready_o high after E2. A new command can be accepted at E2+1 at the earliest, so back-to-back throughput is one transaction per 3 cycles minimum.
- Timeout counter (see Configuration):
  - Cleared on entry to BUS; increments each BUS cycle without ack.
  - On the edge where the count reaches TIMEOUT with no ack: drop cyc/stb, rsp_err_o = 1, rsp_dat_o = 0, go to RESP.
  - Ack and expiry on the same edge: ack wins (err = 0, normal data).
- rsp_dat_o and rsp_err_o are stable for the whole time rsp_valid_o is high.

## Configuration
- WB_CMD_MASTER_TIMEOUT_EN:
  - Defined: TW-bit counter and abort path present, as described above.
  - Undefined: no counter, BUS waits for ack indefinitely, rsp_err_o tied 0, TIMEOUT/TW ignored.

## Test plan
- Write, slave acks 1 cycle after stb:
  - Stimulus: cmd we = 1, adr = 0x3000_0004, dat = 0xA5A5_0001, sel = 0xF.
  - Required: wbm_* carry those values with cyc/stb high for exactly 1 cycle; rsp_valid_o with dat = 0, err = 0; latency 2 cycles.
- Read with 3 wait states:
  - Stimulus: slave returns 0x1234_5678.
  - Required: cyc/stb high 4 cycles; rsp_dat_o = 0x1234_5678; response held 5 cycles while rsp_ready_i = 0, values stable.
- Timeout (macro defined, TIMEOUT = 8):
  - Stimulus: slave never acks.
  - Required: cyc/stb drop after 8 BUS cycles; rsp_err_o = 1, rsp_dat_o = 0. A repeat run with ack on the 8th edge gives err = 0.
- Handshake integrity:
  - Stimulus: cmd_valid_i held high during BUS/RESP with changing cmd_adr_i.
  - Required: no second accept until the response is taken; the wbm_adr_o of the next cycle equals the value present at the accept edge.
- Reset mid-BUS:
  - Stimulus: assert wb_rst_i asynchronously during a read.
  - Required: cyc/stb/rsp_valid_o go 0 without a clock edge; after release cmd_ready_o = 1 and no response for the aborted read.
- Macro undefined:
  - Stimulus: slave acks after 1000 cycles.
  - Required: cyc held 1000 cycles; normal response with err = 0.
